wb_decoder_nport: RTL
=====================

Name: wb_decoder_nport

Overview:
- Registered 1-to-N Wishbone B4 classic decoder between the Caravel user-area slave port and N peripheral slaves.
- Successor to the fixed six-slave combinational interconnect. Slave count, address map and data width are parameters.
- Adds registered request/response paths, a per-transaction timeout watchdog and an error response for unmapped accesses, timeouts and slave errors.
- Adds sticky error-capture status for firmware and interrupts.

Parameters:
- N_SLAVES, 6, number of downstream slaves (1..16).
- DATA_W, 32, data width (multiple of 8). Select width is DATA_W/8.
- SLV_BASE, {0x3000_2000, 0x3000_1000, 0x3000_0300, 0x3000_0200, 0x3000_0100, 0x3000_0000}, flattened N×32 base vector. Slot i occupies bits [32i+31:32i].
- SLV_MASK, N copies of 0xFFFF_FF00, flattened N×32 mask vector. A 1 marks a decoded address bit.
- TIMEOUT_CYCLES, 255, maximum wait cycles in BUSY. 0 disables the watchdog.
- ERR_AS_ACK, 1, 1 means errors are signalled on wbs_ack_o with ERR_DATA (Caravel has no err line). 0 means errors use wbs_err_o.
- ERR_DATA, 0xDEAD_C0DE, read data returned on error.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  asynchronous reset, active low
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master control
- wbs_sel_i  in  DATA_W/8  byte select
- wbs_adr_i  in  32  address
- wbs_dat_i  in  DATA_W  write data
- wbs_dat_o  out  DATA_W  read data
- wbs_ack_o  out  1  acknowledge
- wbs_err_o  out  1  error (held 0 when ERR_AS_ACK=1)
- s_cyc_o, s_stb_o  out  N_SLAVES  one-hot per-slave cycle and strobe
- s_we_o  out  1  broadcast write enable
- s_sel_o  out  DATA_W/8  broadcast byte select
- s_adr_o  out  32  broadcast local offset (adr & ~mask of selected slave)
- s_dat_o  out  DATA_W  broadcast write data
- s_dat_i  in  N_SLAVES×DATA_W  flattened slave read data
- s_ack_i, s_err_i  in  N_SLAVES  slave acknowledge and error
- err_cause_o  out  2  captured cause: 00 none, 01 unmapped, 10 timeout, 11 slave err
- err_addr_o  out  32  captured full address of the failing access
- err_irq_o  out  1  high whenever err_cause_o != 00
- err_clr_i  in  1  single-cycle pulse that clears the capture

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0, capture cleared.
- Decode: hit_i = ((adr & MASK_i) == (BASE_i & MASK_i)). The lowest matching index wins.
- All slave-side outputs are registered. s_adr_o, s_we_o, s_sel_o and s_dat_o are latched on request accept and held for the whole transaction.
- FSM states: IDLE, BUSY, RESP.
- IDLE, cyc&stb with a hit:
  - latch index, address, control and data;
  - next edge asserts s_cyc_o[idx] and s_stb_o[idx];
  - go to BUSY, counter cleared.
- IDLE, cyc&stb with no hit: go to RESP with an error response. Cause 01.
- BUSY exits (priority: master abort > err > ack > timeout):
  - s_ack_i[idx]: deassert the slave strobes, register s_dat_i[idx], go to RESP with wbs_ack_o=1.
  - s_err_i[idx]: deassert the slave strobes, go to RESP with an error response. Cause 11.
  - counter == TIMEOUT_CYCLES-1 with no ack/err: deassert the slave strobes, go to RESP with an error response. Cause 10.
  - otherwise the counter increments and saturates.
- Master abort (wbs_cyc_i low in BUSY): drop the slave strobes, go to IDLE, no response, no capture.
- RESP:
  - ack or err is high for exactly one cycle;
  - wbs_dat_o is valid on reads and otherwise 0;
  - next state is IDLE.
- Error response:
  - ERR_AS_ACK=1: wbs_ack_o=1 with wbs_dat_o=ERR_DATA;
  - ERR_AS_ACK=0: wbs_err_o=1 with wbs_dat_o=0.
- Latency: a zero-wait slave gives an ack 2 edges after the request is sampled. An unmapped access gives its response 1 edge after.
- Back-to-back requests are accepted in the IDLE cycle after RESP.
- Capture: written only while err_cause_o==00, so the first error is kept. When a new error and err_clr_i occur in the same cycle, the new error is captured.
- Reset mid-transaction: everything returns to IDLE and zero asynchronously. No response is issued.

Decomposition:
- Package wb_dec_pkg holds:
  - FSM state enum;
  - err-cause encodings;
  - default base/mask constants for the user-project map;
  - the function that extracts slot i from the flattened vectors.
- Sub-module wb_addr_decode: combinational priority hit to one-hot, plus index, hit and local offset.

Test Plan:
- Read 0x3000_0104 while slave 1 acks in the first BUSY cycle with 0x1234_5678 → s_adr_o=0x04 and s_stb_o=6'b000010; wbs_ack_o rises 2 edges after the request with wbs_dat_o=0x1234_5678.
- Write 0x3000_2008, data 0xA5A5_A5A5, sel 4'b0011, slave 5 waits 3 cycles → s_dat_o and s_sel_o stable for all 4 BUSY cycles, exactly one wbs_ack_o pulse.
- Read unmapped 0x3000_0500 with ERR_AS_ACK=1 → ack after 1 edge with data 0xDEAD_C0DE; err_cause_o=01, err_addr_o=0x3000_0500, err_irq_o=1.
- Slave 4 never acks, TIMEOUT_CYCLES=8 → strobes drop after 8 BUSY cycles, error response issued, cause 10 kept even though a later slave-error access occurs; err_clr_i clears it to 00.
- Slave 2 asserts ack and err in the same cycle → error response (cause 11); second run with ERR_AS_ACK=0 → wbs_err_o pulses and wbs_ack_o stays 0.
- Master drops cyc in BUSY, then wb_rst_n_i is pulsed low mid-transaction → no response, s_cyc_o=0, FSM back in IDLE, and the next access to 0x3000_0000 completes normally.

Source files
------------

// File: rtl/wb_dec_pkg.sv
// Shared types and defaults for the registered N-port Wishbone decoder.
// Holds the FSM/error encodings, the default user-project map and the slot extractor.
package wb_dec_pkg;

  localparam int unsigned MaxSlaves = 16;
  localparam int unsigned DefSlaves = 6;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'b00,
    ErrUnmapped = 2'b01,
    ErrTimeout  = 2'b10,
    ErrSlave    = 2'b11
  } err_cause_e;

  localparam logic [DefSlaves*32-1:0] DefaultBase = {
    32'h3000_2000, 32'h3000_1000, 32'h3000_0300,
    32'h3000_0200, 32'h3000_0100, 32'h3000_0000
  };

  localparam logic [DefSlaves*32-1:0] DefaultMask = {DefSlaves{32'hFFFF_FF00}};

  // Slot i of a flattened 32-bit-per-slot vector, zero-extended to the maximum slave count.
  function automatic logic [31:0] get_slot(input logic [MaxSlaves*32-1:0] vec,
                                           input int unsigned i);
    return vec[i*32 +: 32];
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: lowest-index matching slot wins.
// Produces hit flag, binary index, one-hot select and the slot-local offset.
module wb_addr_decode
  import wb_dec_pkg::*;
#(
  parameter int unsigned              N_SLAVES = DefSlaves,
  parameter int unsigned              IDX_W    = 3,
  parameter logic [N_SLAVES*32-1:0]   SLV_BASE = DefaultBase,
  parameter logic [N_SLAVES*32-1:0]   SLV_MASK = DefaultMask
) (
  input  logic [31:0]         adr_i,
  output logic                hit_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic [N_SLAVES-1:0] onehot_o,
  output logic [31:0]         offset_o
);

  localparam logic [MaxSlaves*32-1:0] BaseExt = (MaxSlaves*32)'(SLV_BASE);
  localparam logic [MaxSlaves*32-1:0] MaskExt = (MaxSlaves*32)'(SLV_MASK);

  always_comb begin
    logic        found;
    logic [31:0] base;
    logic [31:0] mask;
    found    = 1'b0;
    hit_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    offset_o = '0;
    base     = '0;
    mask     = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      base = get_slot(BaseExt, i);
      mask = get_slot(MaskExt, i);
      if (!found && ((adr_i & mask) == (base & mask))) begin
        found       = 1'b1;
        hit_o       = 1'b1;
        idx_o       = IDX_W'(i);
        onehot_o[i] = 1'b1;
        offset_o    = adr_i & ~mask;
      end
    end
  end

endmodule

// File: rtl/wb_decoder_nport.sv
// Registered 1-to-N Wishbone B4 classic decoder with timeout watchdog, error
// responses for unmapped/timeout/slave errors, and sticky first-error capture.
module wb_decoder_nport
  import wb_dec_pkg::*;
#(
  parameter int unsigned            N_SLAVES       = DefSlaves,
  parameter int unsigned            DATA_W         = 32,
  parameter logic [N_SLAVES*32-1:0] SLV_BASE       = DefaultBase,
  parameter logic [N_SLAVES*32-1:0] SLV_MASK       = DefaultMask,
  parameter int unsigned            TIMEOUT_CYCLES = 255,
  parameter bit                     ERR_AS_ACK     = 1'b1,
  parameter logic [DATA_W-1:0]      ERR_DATA       = DATA_W'(32'hDEAD_C0DE)
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [DATA_W/8-1:0]        wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [DATA_W-1:0]          wbs_dat_i,
  output logic [DATA_W-1:0]          wbs_dat_o,
  output logic                       wbs_ack_o,
  output logic                       wbs_err_o,
  output logic [N_SLAVES-1:0]        s_cyc_o,
  output logic [N_SLAVES-1:0]        s_stb_o,
  output logic                       s_we_o,
  output logic [DATA_W/8-1:0]        s_sel_o,
  output logic [31:0]                s_adr_o,
  output logic [DATA_W-1:0]          s_dat_o,
  input  logic [N_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [N_SLAVES-1:0]        s_ack_i,
  input  logic [N_SLAVES-1:0]        s_err_i,
  output logic [1:0]                 err_cause_o,
  output logic [31:0]                err_addr_o,
  output logic                       err_irq_o,
  input  logic                       err_clr_i
);

  localparam int unsigned SelW = DATA_W / 8;
  localparam int unsigned IdxW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [N_SLAVES-1:0]   cyc_q, cyc_d;
  logic                  s_we_q, s_we_d;
  logic [SelW-1:0]       s_sel_q, s_sel_d;
  logic [31:0]           s_adr_q, s_adr_d;
  logic [DATA_W-1:0]     s_dat_q, s_dat_d;
  logic [31:0]           req_adr_q, req_adr_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdat_q, rdat_d;
  err_cause_e            err_cause_q, err_cause_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic                  dec_hit;
  logic [IdxW-1:0]       dec_idx;
  logic [N_SLAVES-1:0]   dec_onehot;
  logic [31:0]           dec_offset;
  logic                  timeout_hit;

  wb_addr_decode #(
    .N_SLAVES (N_SLAVES),
    .IDX_W    (IdxW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_addr_decode (
    .adr_i    (wbs_adr_i),
    .hit_o    (dec_hit),
    .idx_o    (dec_idx),
    .onehot_o (dec_onehot),
    .offset_o (dec_offset)
  );

  // A zero timeout disables the watchdog entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    logic       resp_err;
    logic       resp_we;
    err_cause_e new_cause;
    logic [31:0] new_addr;

    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    s_we_d    = s_we_q;
    s_sel_d   = s_sel_q;
    s_adr_d   = s_adr_q;
    s_dat_d   = s_dat_q;
    req_adr_d = req_adr_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdat_d    = '0;
    resp_err  = 1'b0;
    resp_we   = s_we_q;
    new_cause = ErrNone;
    new_addr  = req_adr_q;

    unique case (state_q)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (dec_hit) begin
            idx_d     = dec_idx;
            cyc_d     = dec_onehot;
            s_we_d    = wbs_we_i;
            s_sel_d   = wbs_sel_i;
            s_adr_d   = dec_offset;
            s_dat_d   = wbs_dat_i;
            req_adr_d = wbs_adr_i;
            cnt_d     = '0;
            state_d   = StBusy;
          end else begin
            resp_err  = 1'b1;
            resp_we   = wbs_we_i;
            new_cause = ErrUnmapped;
            new_addr  = wbs_adr_i;
            state_d   = StResp;
          end
        end
      end
      StBusy: begin
        if (!wbs_cyc_i) begin
          cyc_d   = '0;
          state_d = StIdle;
        end else if (s_err_i[idx_q]) begin
          cyc_d     = '0;
          resp_err  = 1'b1;
          new_cause = ErrSlave;
          state_d   = StResp;
        end else if (s_ack_i[idx_q]) begin
          cyc_d   = '0;
          ack_d   = 1'b1;
          rdat_d  = s_we_q ? '0 : s_dat_i[idx_q*DATA_W +: DATA_W];
          state_d = StResp;
        end else if (timeout_hit) begin
          cyc_d     = '0;
          resp_err  = 1'b1;
          new_cause = ErrTimeout;
          state_d   = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (resp_err) begin
      if (ERR_AS_ACK) begin
        ack_d  = 1'b1;
        rdat_d = resp_we ? '0 : ERR_DATA;
      end else begin
        err_d = 1'b1;
      end
    end

    // First error is sticky; a clear in the same cycle lets the new error through.
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    if (err_clr_i) begin
      err_cause_d = ErrNone;
      err_addr_d  = '0;
    end
    if ((new_cause != ErrNone) && ((err_cause_q == ErrNone) || err_clr_i)) begin
      err_cause_d = new_cause;
      err_addr_d  = new_addr;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      cyc_q       <= '0;
      s_we_q      <= 1'b0;
      s_sel_q     <= '0;
      s_adr_q     <= '0;
      s_dat_q     <= '0;
      req_adr_q   <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdat_q      <= '0;
      err_cause_q <= ErrNone;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      s_we_q      <= s_we_d;
      s_sel_q     <= s_sel_d;
      s_adr_q     <= s_adr_d;
      s_dat_q     <= s_dat_d;
      req_adr_q   <= req_adr_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdat_q      <= rdat_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign wbs_dat_o   = rdat_q;
  assign s_cyc_o     = cyc_q;
  assign s_stb_o     = cyc_q;
  assign s_we_o      = s_we_q;
  assign s_sel_o     = s_sel_q;
  assign s_adr_o     = s_adr_q;
  assign s_dat_o     = s_dat_q;
  assign err_cause_o = err_cause_q;
  assign err_addr_o  = err_addr_q;
  assign err_irq_o   = (err_cause_q != ErrNone);

endmodule
